instr_injector: RTL and testbench

Parametrised instruction feeder between a test host and the CPU's injected-instruction port (`mode`/`instr_in`). The host pushes instruction words into a FIFO. The block then releases them to the CPU either back-to-back (run) or one per `step` pulse (single-step). It detects CPU halt and enforces a cycle-count timeout, so directed instruction sequences run under hardware control rather than hand-timed bench stimulus.

---
 rtl/instr_injector.sv | 157 +++++++++++++++
 tb/tb_instr_injector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_injector.sv
// Instruction feeder: host FIFO -> CPU injected-instruction port, run/single-step, halt + timeout (breakpoints with INJ_BKPT_EN).
// Latency: push into empty FIFO reaches instr_out 2 cycles later in RUN; instr_out/instr_valid are registered.
// Backpressure: none upstream; wr_en while full drops the word and sets sticky ovf.
module instr_injector #(
    parameter int               WIDTH   = 16,
    parameter int               DEPTH   = 8,
    parameter logic [WIDTH-1:0] NOP     = '0,
    parameter int               TIMEOUT = 100000,
    parameter int               CNT_W   = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         run,
    input  logic                         step,
    input  logic                         hlt,
`ifdef INJ_BKPT_EN
    input  logic [15:0]                  pc,
    input  logic                         bkpt_en,
    input  logic [15:0]                  bkpt_addr,
`endif
    output logic                         mode,
    output logic [WIDTH-1:0]             instr_out,
    output logic                         instr_valid,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_W-1:0]             cycle_count,
    output logic                         halted,
    output logic                         timeout,
    output logic                         ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {IDLE, RUN, STEP, HALT, TOUT} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CNT_W-1:0] cyc_inc;
    logic             active;
    logic             at_limit;
    logic             push;
    logic             pop;
    logic             bkpt_hit;
    logic             bkpt_hold;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign active   = (state == RUN) || (state == STEP);
    assign cyc_inc  = cycle_count + 1'b1;
    assign at_limit = (cyc_inc == CNT_W'(TIMEOUT));
    assign push     = wr_en && !full;
    // Halt and timeout both pre-empt the pop on the cycle they are taken.
    assign pop      = active && !hlt && !at_limit && !empty && ((state == RUN) || step);

`ifdef INJ_BKPT_EN
    assign bkpt_hit = (state == RUN) && bkpt_en && (pc == bkpt_addr);

    // Holds STEP after a breakpoint until the host drops run, so a stuck-high run cannot resume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bkpt_hold <= 1'b0;
        end else if (clr) begin
            bkpt_hold <= 1'b0;
        end else if (bkpt_hit) begin
            bkpt_hold <= 1'b1;
        end else if (!run) begin
            bkpt_hold <= 1'b0;
        end
    end
`else
    assign bkpt_hit  = 1'b0;
    assign bkpt_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode        <= 1'b0;
            instr_out   <= NOP;
            instr_valid <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            ovf         <= 1'b0;
        end else if (clr) begin
            state       <= IDLE;
            mode        <= 1'b0;
            instr_out   <= NOP;
            instr_valid <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            if (wr_en && full) begin
                ovf <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            instr_out   <= pop ? mem[rd_ptr] : NOP;
            instr_valid <= pop;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= run ? RUN : STEP;
                        mode  <= 1'b1;
                    end
                end
                RUN, STEP: begin
                    if (hlt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (at_limit) begin
                        cycle_count <= cyc_inc;
                        state       <= TOUT;
                        timeout     <= 1'b1;
                    end else begin
                        cycle_count <= cyc_inc;
                        state       <= (run && !bkpt_hold && !bkpt_hit) ? RUN : STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_injector.sv
// Scoreboarded bench for instr_injector: queue-level reference model, randomized plus directed traffic.
module tb_instr_injector;

    localparam int          WIDTH   = 16;
    localparam int          DEPTH   = 8;
    localparam logic [15:0] NOP_W   = 16'h0F0F;
    localparam int          TIMEOUT = 20;
    localparam int          CNT_W   = 17;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_STEP = 2;
    localparam int S_HALT = 3;
    localparam int S_TOUT = 4;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             run;
    logic             step;
    logic             hlt;
    logic             mode;
    logic [WIDTH-1:0] instr_out;
    logic             instr_valid;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic [CNT_W-1:0] cycle_count;
    logic             halted;
    logic             timeout;
    logic             ovf;

    instr_injector #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(NOP_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .run(run), .step(step), .hlt(hlt), .mode(mode), .instr_out(instr_out),
        .instr_valid(instr_valid), .full(full), .empty(empty), .count(count),
        .cycle_count(cycle_count), .halted(halted), .timeout(timeout), .ovf(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    // Reference model: FIFO contents, control state, counters and flags.
    logic [15:0] m_q[$];
    logic [15:0] exp_q[$];
    int          m_st;
    int          m_cyc;
    bit          m_halted;
    bit          m_tout;
    bit          m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_st     = S_IDLE;
        m_cyc    = 0;
        m_halted = 0;
        m_tout   = 0;
        m_ovf    = 0;
    endtask

    task automatic model_step(input logic c, input logic w, input logic [15:0] d,
                              input logic r, input logic s, input logic h);
        int n;
        bit popd;
        n    = m_q.size();
        popd = 0;
        if (c) begin
            model_reset();
            return;
        end
        case (m_st)
            S_IDLE: if (n > 0) m_st = r ? S_RUN : S_STEP;
            S_RUN, S_STEP: begin
                if (h) begin
                    m_st     = S_HALT;
                    m_halted = 1;
                end else begin
                    m_cyc++;
                    if (m_cyc == TIMEOUT) begin
                        m_st   = S_TOUT;
                        m_tout = 1;
                    end else begin
                        popd = (n > 0) && (m_st == S_RUN || s);
                        m_st = r ? S_RUN : S_STEP;
                    end
                end
            end
            default: ;
        endcase
        if (popd) exp_q.push_back(m_q.pop_front());
        if (w) begin
            if (n == DEPTH) m_ovf = 1;
            else m_q.push_back(d);
        end
    endtask

    // Inputs change just after the falling edge; the model advances with them.
    task automatic drive(input logic c, input logic w, input logic [15:0] d,
                         input logic r, input logic s, input logic h);
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        clr     = c;
        wr_en   = w;
        wr_data = d;
        run     = r;
        step    = s;
        hlt     = h;
        model_step(c, w, d, r, s, h);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_instr_out", 32'(instr_out), 32'(NOP_W));
        chk("arst_valid", 32'(instr_valid), 0);
        chk("arst_mode", 32'(mode), 0);
        chk("arst_count", 32'(count), 0);
        model_reset();
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard on every valid issue and compares status to the model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (instr_valid === 1'b1) begin
                chk("issue_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("instr_out", 32'(instr_out), 32'(exp_q.pop_front()));
            end else begin
                chk("bubble_nop", 32'(instr_out), 32'(NOP_W));
            end
            chk("mode", 32'(mode), 32'(m_st != S_IDLE));
            chk("count", 32'(count), 32'(m_q.size()));
            chk("full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(m_q.size() == 0));
            chk("cycle_count", 32'(cycle_count), 32'(m_cyc));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("timeout", 32'(timeout), 32'(m_tout));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    logic        r_lvl;
    logic [15:0] rnd_d;

    initial begin
        rst_n = 1'b1; clr = 0; wr_en = 0; wr_data = '0; run = 0; step = 0; hlt = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_instr_out", 32'(instr_out), 32'(NOP_W));
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_cycle", 32'(cycle_count), 0);
        model_reset();
        mon_en = 1;

        // Free-run burst
        drive(0, 1, 16'hB112, 1, 0, 0);
        drive(0, 1, 16'hA134, 1, 0, 0);
        drive(0, 1, 16'hB2B0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 1, 0, 0);
        chk("run_drained_count", 32'(count), 0);
        chk("run_bubble_valid", 32'(instr_valid), 0);

        // Single-step, pulses three cycles apart
        drive(1, 0, 16'h0, 0, 0, 0);
        drive(0, 1, 16'h9122, 0, 0, 0);
        drive(0, 1, 16'h0523, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 1, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 1, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        chk("step_count", 32'(count), 0);

        // Full and overflow
        drive(1, 0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 16'h1000 + 16'(i), 0, 0, 0);
        chk("full_after_8", 32'(full), 1);
        chk("no_ovf_after_8", 32'(ovf), 0);
        drive(0, 0, 16'h0, 1, 0, 0);
        chk("ovf_after_9", 32'(ovf), 1);
        chk("count_after_9", 32'(count), 8);
        for (int i = 0; i < 9; i++) drive(0, 0, 16'h0, 1, 0, 0);

        // Halt while F000 is on instr_out
        drive(1, 0, 16'h0, 1, 0, 0);
        drive(0, 1, 16'h8450, 1, 0, 0);
        drive(0, 1, 16'hF000, 1, 0, 0);
        drive(0, 1, 16'h7542, 1, 0, 0);
        drive(0, 0, 16'h0, 1, 0, 0);
        drive(0, 0, 16'h0, 1, 0, 1);
        drive(0, 0, 16'h0, 1, 0, 0);
        drive(0, 0, 16'h0, 1, 0, 0);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_count", 32'(count), 1);
        chk("halt_cycle", 32'(cycle_count), 2);
        drive(0, 0, 16'h0, 1, 0, 0);
        drive(0, 0, 16'h0, 1, 0, 0);
        chk("halt_cycle_frozen", 32'(cycle_count), 2);

        // Timeout in STEP with no step pulses
        drive(1, 0, 16'h0, 0, 0, 0);
        drive(0, 1, 16'h5A5A, 0, 0, 0);
        for (int i = 0; i < 24; i++) drive(0, 0, 16'h0, 0, 0, 0);
        chk("tout_flag", 32'(timeout), 1);
        chk("tout_cycle", 32'(cycle_count), 20);
        chk("tout_count", 32'(count), 1);
        drive(1, 0, 16'h0, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        chk("clr_tout", 32'(timeout), 0);
        chk("clr_cycle", 32'(cycle_count), 0);
        chk("clr_mode", 32'(mode), 0);
        chk("clr_empty", 32'(empty), 1);

        // Asynchronous reset while a word is on instr_out
        drive(1, 0, 16'h0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 16'hC000 + 16'(i), 1, 0, 0);
        async_reset();

        // Randomized traffic
        r_lvl = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) r_lvl = ~r_lvl;
            rnd_d = 16'($urandom);
            drive(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), rnd_d,
                  r_lvl, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 59) == 0));
        end

        drive(1, 0, 16'h0, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
